// File: rtl/audio_i2s_tx.sv
// Purpose: final audio stage; holds one 16-bit stereo sample and serializes it as Philips I2S.
// Latency: a sample written to the hold buffer is loaded at the next frame start; first data bit follows one SCLK later.
// Backpressure: none; upstream paces itself on frame_ce, and a frame without a new sample repeats the old one and counts an underrun.
//
// Ports:
//   clk, reset_n            - audio clock, asynchronous active-low reset
//   enable                  - run the serializer; low forces outputs idle and clears the counters
//   in_valid, in_l, in_r    - one-cycle write strobe and stereo sample into the hold buffer
//   frame_ce                - one-cycle pulse at each frame load (slot 0 start)
//   sclk, lrck, sdata       - I2S bit clock, word select (1 = right), serial data MSB first
//   underrun, underrun_cnt  - stale-frame pulse and saturating count of them
module audio_i2s_tx #(
    parameter int SCLK_DIV  = 4,
    parameter int SLOT_BITS = 32,
    parameter int SAMPLE_W  = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic                in_valid,
    input  logic [SAMPLE_W-1:0] in_l,
    input  logic [SAMPLE_W-1:0] in_r,
    output logic                frame_ce,
    output logic                sclk,
    output logic                lrck,
    output logic                sdata,
    output logic                underrun,
    output logic [15:0]         underrun_cnt
);

    localparam int PH_W   = (SCLK_DIV > 2) ? $clog2(SCLK_DIV) : 1;
    localparam int SLOT_W = $clog2(2 * SLOT_BITS);

    localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(SCLK_DIV - 1);
    localparam logic [PH_W-1:0]   PH_HALF   = PH_W'(SCLK_DIV / 2);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(2 * SLOT_BITS - 1);
    localparam logic [SLOT_W-1:0] R_SLOT0   = SLOT_W'(SLOT_BITS);
    localparam logic [SLOT_W-1:0] L_FIRST   = SLOT_W'(1);
    localparam logic [SLOT_W-1:0] L_LAST    = SLOT_W'(SAMPLE_W);
    localparam logic [SLOT_W-1:0] R_FIRST   = SLOT_W'(SLOT_BITS + 1);
    localparam logic [SLOT_W-1:0] R_LAST    = SLOT_W'(SLOT_BITS + SAMPLE_W);

    logic [PH_W-1:0]     ph;
    logic [SLOT_W-1:0]   slot;
    logic                armed;     // a falling edge has occurred since enable rose
    logic [SAMPLE_W-1:0] hold_l, hold_r;
    logic                fresh;
    logic [SAMPLE_W-1:0] sh_l, sh_r;

    logic                fall;
    logic [PH_W-1:0]     ph_nxt;
    logic [SLOT_W-1:0]   slot_nxt;
    logic                load;
    logic                left_bit, right_bit;

    always_comb begin
        fall      = enable && (ph == PH_LAST);
        ph_nxt    = fall ? '0 : ph + PH_W'(1);
        // The first falling edge after enable behaves as a wrap from the last
        // slot, so it always opens a fresh frame at slot 0.
        slot_nxt  = (!armed || slot == SLOT_LAST) ? '0 : slot + SLOT_W'(1);
        load      = fall && (slot_nxt == '0);
        left_bit  = (slot_nxt >= L_FIRST) && (slot_nxt <= L_LAST);
        right_bit = (slot_nxt >= R_FIRST) && (slot_nxt <= R_LAST);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ph           <= '0;
            slot         <= '0;
            armed        <= 1'b0;
            sclk         <= 1'b0;
            lrck         <= 1'b0;
            sdata        <= 1'b0;
            frame_ce     <= 1'b0;
            underrun     <= 1'b0;
            underrun_cnt <= '0;
            sh_l         <= '0;
            sh_r         <= '0;
        end else begin
            frame_ce <= 1'b0;
            underrun <= 1'b0;
            if (!enable) begin
                ph    <= '0;
                slot  <= '0;
                armed <= 1'b0;
                sclk  <= 1'b0;
                lrck  <= 1'b0;
                sdata <= 1'b0;
            end else begin
                ph   <= ph_nxt;
                sclk <= (ph_nxt >= PH_HALF);
                if (fall) begin
                    slot  <= slot_nxt;
                    armed <= 1'b1;
                    // Word select leads the data by one SCLK: slot 0 / slot
                    // SLOT_BITS carry no data bit.
                    lrck  <= (slot_nxt >= R_SLOT0);
                    if (load) begin
                        sh_l     <= hold_l;
                        sh_r     <= hold_r;
                        sdata    <= 1'b0;
                        frame_ce <= 1'b1;
                        if (!fresh) begin
                            underrun <= 1'b1;
                            if (underrun_cnt != 16'hFFFF) begin
                                underrun_cnt <= underrun_cnt + 16'd1;
                            end
                        end
                    end else if (left_bit) begin
                        sdata <= sh_l[SAMPLE_W-1];
                        sh_l  <= {sh_l[SAMPLE_W-2:0], 1'b0};
                    end else if (right_bit) begin
                        sdata <= sh_r[SAMPLE_W-1];
                        sh_r  <= {sh_r[SAMPLE_W-2:0], 1'b0};
                    end else begin
                        sdata <= 1'b0;
                    end
                end
            end
        end
    end

    // Hold buffer: a write in the load cycle lands after the load has taken
    // the old contents, so it stays fresh for the following frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_l <= '0;
            hold_r <= '0;
            fresh  <= 1'b0;
        end else if (in_valid) begin
            hold_l <= in_l;
            hold_r <= in_r;
            fresh  <= 1'b1;
        end else if (load) begin
            fresh  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_audio_i2s_tx.sv
module tb_audio_i2s_tx;

    localparam int DIV   = 4;
    localparam int SB    = 32;
    localparam int SW    = 16;
    localparam int FRAME = DIV * 2 * SB;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_l = '0, in_r = '0;
    logic        frame_ce, sclk, lrck, sdata, underrun;
    logic [15:0] underrun_cnt;

    audio_i2s_tx #(.SCLK_DIV(DIV), .SLOT_BITS(SB), .SAMPLE_W(SW)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .in_valid(in_valid),
        .in_l(in_l), .in_r(in_r), .frame_ce(frame_ce), .sclk(sclk), .lrck(lrck),
        .sdata(sdata), .underrun(underrun), .underrun_cnt(underrun_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_on = 0;

    // Reference model: counts enabled clock edges since enable rose and
    // derives phase, slot and frame purely arithmetically.
    int          n = -1;
    int          mp, mf, ms;
    logic [15:0] m_hold_l = '0, m_hold_r = '0, m_cur_l = '0, m_cur_r = '0;
    bit          m_fresh = 0;
    logic [15:0] m_cnt = '0;
    bit          e_fce = 0, e_sclk = 0, e_lrck = 0, e_sdata = 0, e_under = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            n = -1; m_hold_l = '0; m_hold_r = '0; m_cur_l = '0; m_cur_r = '0;
            m_fresh = 0; m_cnt = '0;
            e_fce = 0; e_sclk = 0; e_lrck = 0; e_sdata = 0; e_under = 0;
        end else begin
            e_fce = 0; e_under = 0;
            if (!enable) begin
                n = -1; e_sclk = 0; e_lrck = 0; e_sdata = 0;
            end else begin
                n++;
                mp = (n + 1) % DIV;
                mf = (n + 1) / DIV;
                e_sclk = (mp >= DIV / 2);
                if (mf == 0) begin
                    e_lrck = 0; e_sdata = 0;
                end else begin
                    ms = (mf - 1) % (2 * SB);
                    e_lrck = (ms >= SB);
                    if (mp == 0 && ms == 0) begin
                        m_cur_l = m_hold_l; m_cur_r = m_hold_r;
                        e_fce = 1;
                        if (!m_fresh) begin
                            e_under = 1;
                            if (m_cnt != 16'hFFFF) m_cnt++;
                        end
                        m_fresh = 0;
                    end
                    if (ms >= 1 && ms <= SW)                e_sdata = m_cur_l[SW - ms];
                    else if (ms >= SB + 1 && ms <= SB + SW) e_sdata = m_cur_r[SW - (ms - SB)];
                    else                                    e_sdata = 0;
                end
            end
            if (in_valid) begin
                m_hold_l = in_l; m_hold_r = in_r; m_fresh = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            checks++;
            if ({frame_ce, sclk, lrck, sdata, underrun, underrun_cnt} !==
                {e_fce, e_sclk, e_lrck, e_sdata, e_under, m_cnt}) begin
                errors++;
                $display("FAIL model_cycle t=%0t got fce=%b sclk=%b lrck=%b sd=%b ur=%b cnt=%0d want fce=%b sclk=%b lrck=%b sd=%b ur=%b cnt=%0d",
                         $time, frame_ce, sclk, lrck, sdata, underrun, underrun_cnt,
                         e_fce, e_sclk, e_lrck, e_sdata, e_under, m_cnt);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, exp);
        end
    endtask

    task automatic pulse(input logic [15:0] l, input logic [15:0] r);
        in_l = l; in_r = r; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    time t_fce;

    task automatic wait_fce(output bit ur);
        bit ok = 0;
        ur = 0;
        for (int i = 0; i < 2 * FRAME && !ok; i++) begin
            @(negedge clk);
            if (frame_ce) begin
                ok = 1; ur = underrun; t_fce = $time;
            end
        end
        check("fce_seen", {31'd0, ok}, 32'd1);
    endtask

    // Called just after frame_ce; collects the bits present at each sclk
    // rising edge up to the last right-channel data slot.
    task automatic capture(output logic [15:0] l, output logic [15:0] r);
        logic prev = sclk;
        int   k = 0;
        l = '0; r = '0;
        for (int i = 0; i < FRAME && k <= SB + SW; i++) begin
            @(negedge clk);
            if (sclk && !prev) begin
                if (k >= 1 && k <= SW)           l[SW - k] = sdata;
                if (k >= SB + 1 && k <= SB + SW) r[SW - (k - SB)] = sdata;
                k++;
            end
            prev = sclk;
        end
        check("capture_slots", k, SB + SW + 1);
    endtask

    typedef struct {
        int          n_wr;
        logic [15:0] l1, r1, l2, r2;
        logic [15:0] exp_l, exp_r;
        bit          exp_ur;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t        tbl[7];
    bit          ur;
    logic [15:0] cl, cr;
    time         t_prev;

    initial begin
        tbl[0] = '{1, 16'h8001, 16'h7FFE, 16'h0, 16'h0, 16'h8001, 16'h7FFE, 0, 16'd0};
        tbl[1] = '{0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h8001, 16'h7FFE, 1, 16'd1};
        tbl[2] = '{0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h8001, 16'h7FFE, 1, 16'd2};
        tbl[3] = '{2, 16'h1111, 16'hAAAA, 16'h2222, 16'h5555, 16'h2222, 16'h5555, 0, 16'd2};
        tbl[4] = '{1, 16'hFFFF, 16'h0000, 16'h0, 16'h0, 16'hFFFF, 16'h0000, 0, 16'd2};
        tbl[5] = '{1, 16'h0000, 16'hFFFF, 16'h0, 16'h0, 16'h0000, 16'hFFFF, 0, 16'd2};
        tbl[6] = '{0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0000, 16'hFFFF, 1, 16'd3};

        // Reset and idle
        repeat (3) @(negedge clk);
        check("reset_outs", {10'd0, frame_ce, sclk, lrck, sdata, underrun, underrun_cnt}, 32'd0);
        reset_n = 1'b1;
        chk_on = 1;
        repeat (1000) @(negedge clk);
        check("idle_cnt", {16'd0, underrun_cnt}, 32'd0);

        // Frame table: write, wait for the load, read the frame back off the wire
        enable = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (tbl[i].n_wr >= 1) pulse(tbl[i].l1, tbl[i].r1);
            if (tbl[i].n_wr >= 2) pulse(tbl[i].l2, tbl[i].r2);
            t_prev = t_fce;
            wait_fce(ur);
            if (i > 0) check($sformatf("period_%0d", i), 32'(t_fce - t_prev), FRAME * 10);
            check($sformatf("ur_%0d", i), {31'd0, ur}, {31'd0, tbl[i].exp_ur});
            check($sformatf("cnt_%0d", i), {16'd0, underrun_cnt}, {16'd0, tbl[i].exp_cnt});
            capture(cl, cr);
            check($sformatf("left_%0d", i), {16'd0, cl}, {16'd0, tbl[i].exp_l});
            check($sformatf("right_%0d", i), {16'd0, cr}, {16'd0, tbl[i].exp_r});
        end

        // Collision: write lands in the very cycle of the frame load
        wait_fce(ur);
        repeat (FRAME - 1) @(negedge clk);
        in_l = 16'h1234; in_r = 16'hABCD; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("coll_fce", {31'd0, frame_ce}, 32'd1);
        check("coll_ur", {31'd0, underrun}, 32'd1);
        capture(cl, cr);
        check("coll_old_l", {16'd0, cl}, 32'h0000);
        check("coll_old_r", {16'd0, cr}, 32'hFFFF);
        wait_fce(ur);
        check("coll_next_ur", {31'd0, ur}, 32'd0);
        capture(cl, cr);
        check("coll_new_l", {16'd0, cl}, 32'h1234);
        check("coll_new_r", {16'd0, cr}, 32'hABCD);

        // Enable dropped mid-frame at slot 20 while sclk is high
        wait_fce(ur);
        repeat (20 * DIV + 2) @(negedge clk);
        check("pre_drop_sclk", {31'd0, sclk}, 32'd1);
        enable = 1'b0;
        @(negedge clk);
        check("drop_outs", {29'd0, sclk, lrck, sdata}, 32'd0);
        repeat (5) @(negedge clk);
        enable = 1'b1;
        for (int k = 1; k <= DIV; k++) begin
            @(negedge clk);
            check($sformatf("reen_fce_%0d", k), {31'd0, frame_ce}, (k == DIV) ? 32'd1 : 32'd0);
        end

        // Asynchronous reset in the middle of a frame, away from any clock edge
        wait_fce(ur);
        repeat (35 * DIV + 2) @(negedge clk);
        check("pre_rst_cnt_nonzero", {31'd0, underrun_cnt != 16'd0}, 32'd1);
        #2 reset_n = 1'b0;
        #1 check("midrst_outs", {10'd0, frame_ce, sclk, lrck, sdata, underrun, underrun_cnt}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Randomized traffic against the model
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 1999) == 0) enable = ~enable;
            if ($urandom_range(0, 179) == 0) begin
                in_valid = 1'b1;
                in_l = 16'($urandom);
                in_r = 16'($urandom);
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        chk_on = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
